// File: rtl/game_ctrl_if.sv
// Board/datapath bundle for the sequence-memory game controller.
//   enter, level          : board inputs (debounced key level, difficulty)
//   end_FPGA, end_User    : datapath phase-complete flags
//   match                 : datapath compare result
//   R1, R2, E1..E4, SEL   : datapath reset/enable strobes and display select
//   round, win, lose      : game status
//   state_dbg             : controller state encoding
// The controller connects through the slave modport; the board/datapath side uses master.
interface game_ctrl_if #(
  parameter int ROUND_W = 6
);
  logic               enter;
  logic [1:0]         level;
  logic               end_FPGA;
  logic               end_User;
  logic               match;
  logic               R1;
  logic               R2;
  logic               E1;
  logic               E2;
  logic               E3;
  logic               E4;
  logic               SEL;
  logic [ROUND_W-1:0] round;
  logic               win;
  logic               lose;
  logic [2:0]         state_dbg;

  modport master (
    output enter, level, end_FPGA, end_User, match,
    input  R1, R2, E1, E2, E3, E4, SEL, round, win, lose, state_dbg
  );

  modport slave (
    input  enter, level, end_FPGA, end_User, match,
    output R1, R2, E1, E2, E3, E4, SEL, round, win, lose, state_dbg
  );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller for the sequence-memory game.
// Sequences setup, FPGA playback, user entry (with a level-dependent timeout),
// compare and round advance, and holds the win/lose result until the next
// enter press. Outputs are Moore-decoded from the state register.
// Ports:
//   CLOCK : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : game_ctrl_if slave (board inputs, datapath strobes, status)
module game_ctrl_fsm #(
  parameter int MAX_ROUNDS   = 32,
  parameter int ROUND_W      = 6,
  parameter int TIMEOUT_BASE = 500_000_000,
  parameter int TIMER_W      = 29
) (
  input  logic        CLOCK,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  localparam logic [TIMER_W-1:0] BASE = TIMER_W'(TIMEOUT_BASE);

  state_t               state;
  state_t               state_next;
  logic                 enter_q;
  logic                 enter_edge;
  logic [1:0]           level_q;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   limit_m1;
  logic                 timeout;
  logic [ROUND_W-1:0]   round_q;
  logic                 last_round;
  logic                 win_q;
  logic                 lose_q;

  logic r1, r2, e1, e2, e3, e4, sel;

  // enter_q resets to 1 so a key held through reset gives no edge.
  assign enter_edge = bus.enter & ~enter_q;
  assign limit_m1   = (BASE >> level_q) - TIMER_W'(1);
  assign timeout    = (timer == limit_m1);
  assign last_round = (round_q == ROUND_W'(MAX_ROUNDS));

  // State register
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Next-state logic; the illegal code falls to INIT through default
  always_comb begin
    state_next = state;
    case (state)
      INIT:       state_next = SETUP;
      SETUP:      if (enter_edge) state_next = PLAY_FPGA;
      PLAY_FPGA:  if (bus.end_FPGA) state_next = PLAY_USER;
      PLAY_USER: begin
        // end_User wins a tie with the timeout
        if (bus.end_User)  state_next = CHECK;
        else if (timeout)  state_next = RESULT;
      end
      CHECK:      state_next = bus.match ? NEXT_ROUND : RESULT;
      NEXT_ROUND: state_next = last_round ? RESULT : PLAY_FPGA;
      RESULT:     if (enter_edge) state_next = INIT;
      default:    state_next = INIT;
    endcase
  end

  // Datapath registers: enter history, latched level, timer, round, result
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      enter_q <= 1'b1;
      level_q <= '0;
      timer   <= '0;
      round_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      enter_q <= bus.enter;
      // Timer is zero outside PLAY_USER, so every entry starts from 0
      timer   <= '0;
      case (state)
        INIT: begin
          round_q <= '0;
          win_q   <= 1'b0;
          lose_q  <= 1'b0;
        end
        SETUP: begin
          if (enter_edge) begin
            level_q <= bus.level;
            round_q <= ROUND_W'(1);
          end
        end
        PLAY_USER: begin
          if (!bus.end_User) begin
            if (timeout) lose_q <= 1'b1;
            else         timer  <= timer + TIMER_W'(1);
          end
        end
        CHECK: begin
          if (!bus.match) lose_q <= 1'b1;
        end
        NEXT_ROUND: begin
          if (last_round) win_q   <= 1'b1;
          else            round_q <= round_q + ROUND_W'(1);
        end
        RESULT: begin
          if (enter_edge) begin
            round_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    r1  = 1'b0;
    r2  = 1'b0;
    e1  = 1'b0;
    e2  = 1'b0;
    e3  = 1'b0;
    e4  = 1'b0;
    sel = 1'b0;
    case (state)
      INIT: begin
        r1 = 1'b1;
        r2 = 1'b1;
      end
      SETUP:      e1  = 1'b1;
      PLAY_FPGA:  e3  = 1'b1;
      PLAY_USER:  e2  = 1'b1;
      CHECK:      e4  = 1'b1;
      NEXT_ROUND: r2  = 1'b1;
      RESULT:     sel = 1'b1;
      default: ;
    endcase
  end

  assign bus.R1        = r1;
  assign bus.R2        = r2;
  assign bus.E1        = e1;
  assign bus.E2        = e2;
  assign bus.E3        = e3;
  assign bus.E4        = e4;
  assign bus.SEL       = sel;
  assign bus.round     = round_q;
  assign bus.win       = win_q;
  assign bus.lose      = lose_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: directed scenarios followed by
// randomized games, each round checked against game rules computed in the bench.
module tb_game_ctrl_fsm;
  localparam int MAXR = 3;
  localparam int RW   = 4;
  localparam int BASE = 16;
  localparam int TW   = 5;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  game_ctrl_if #(.ROUND_W(RW)) bus ();

  game_ctrl_fsm #(
    .MAX_ROUNDS(MAXR),
    .ROUND_W(RW),
    .TIMEOUT_BASE(BASE),
    .TIMER_W(TW)
  ) dut (
    .CLOCK(CLOCK),
    .reset(reset),
    .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {R1,R2,E1,E2,E3,E4,SEL} expected for each state code
  function automatic logic [6:0] strobes(input int s);
    case (s)
      0:       return 7'b1100000;
      1:       return 7'b0010000;
      2:       return 7'b0000100;
      3:       return 7'b0001000;
      4:       return 7'b0000010;
      5:       return 7'b0100000;
      6:       return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk_state(input string tag, input int s);
    chk({tag, ".state"}, 32'(bus.state_dbg), s);
    chk({tag, ".strobes"}, 32'({bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL}),
        32'(strobes(s)));
  endtask

  task automatic chk_result(input string tag, input int r, input bit w);
    chk_state(tag, 6);
    chk({tag, ".win"}, 32'(bus.win), 32'(w));
    chk({tag, ".lose"}, 32'(bus.lose), 32'(!w));
    chk({tag, ".round"}, 32'(bus.round), r);
  endtask

  // From SETUP: press enter with the given level, land in PLAY_FPGA round 1
  task automatic start_game(input logic [1:0] lvl);
    chk_state("setup", 1);
    chk("setup.round", 32'(bus.round), 0);
    bus.level = lvl;
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    bus.level = 2'($urandom);
    chk_state("start", 2);
    chk("start.round", 32'(bus.round), 1);
  endtask

  // From RESULT: enter edge gives one INIT cycle, then a clean SETUP
  task automatic restart();
    bus.enter = 1'b0;
    tick();
    chk_state("result_hold", 6);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    chk_state("init", 0);
    chk("init.round", 32'(bus.round), 0);
    chk("init.win", 32'(bus.win), 0);
    chk("init.lose", 32'(bus.lose), 0);
    tick();
    chk_state("resetup", 1);
    chk("resetup.round", 32'(bus.round), 0);
    chk("resetup.win", 32'(bus.win), 0);
    chk("resetup.lose", 32'(bus.lose), 0);
  endtask

  // One round from PLAY_FPGA. fd: playback wait cycles; ud: PLAY_USER cycle
  // index at which end_User pulses (>= lim means never); m: compare result.
  task automatic play_round(input int lim, input int r, input int fd, input int ud,
                            input bit m, output bit over);
    over = 1'b0;
    for (int i = 0; i < fd; i++) begin
      chk_state("fpga_wait", 2);
      bus.enter = 1'($urandom);   // enter is ignored during play
      tick();
    end
    bus.enter = 1'b0;
    chk_state("fpga", 2);
    chk("fpga.round", 32'(bus.round), r);
    bus.end_FPGA = 1'b1;
    tick();
    bus.end_FPGA = 1'b0;
    for (int i = 0; i < lim; i++) begin
      chk_state("user", 3);
      bus.end_User = (i == ud);
      tick();
      bus.end_User = 1'b0;
      if (i == ud) break;
    end
    if (ud >= lim) begin
      chk_result("timeout", r, 1'b0);
      over = 1'b1;
      return;
    end
    chk_state("check", 4);
    chk("check.lose", 32'(bus.lose), 0);
    bus.match = m;
    tick();
    bus.match = 1'b0;
    if (!m) begin
      chk_result("mismatch", r, 1'b0);
      over = 1'b1;
      return;
    end
    chk_state("next", 5);
    chk("next.round", 32'(bus.round), r);
    tick();
    if (r == MAXR) begin
      chk_result("won", r, 1'b1);
      over = 1'b1;
    end else begin
      chk_state("advance", 2);
      chk("advance.round", 32'(bus.round), r + 1);
    end
  endtask

  initial begin
    bit over;
    int r;
    int lvl;
    int lim;

    bus.enter    = 1'b0;
    bus.level    = 2'd0;
    bus.end_FPGA = 1'b0;
    bus.end_User = 1'b0;
    bus.match    = 1'b0;

    // Reset and release: one INIT cycle, then SETUP
    tick();
    tick();
    chk_state("reset", 0);
    chk("reset.round", 32'(bus.round), 0);
    chk("reset.win", 32'(bus.win), 0);
    chk("reset.lose", 32'(bus.lose), 0);
    reset = 1'b0;
    chk_state("release", 0);
    tick();
    chk_state("first_setup", 1);
    chk("first_setup.round", 32'(bus.round), 0);

    // Full win at level 0
    start_game(2'd0);
    for (int k = 1; k <= MAXR; k++) play_round(BASE, k, 1, 2, 1'b1, over);
    chk("win.over", 32'(over), 1);
    restart();

    // Timeout at level 2: limit 4
    start_game(2'd2);
    play_round(BASE >> 2, 1, 0, 99, 1'b1, over);
    restart();

    // Mismatch in round 2
    start_game(2'd1);
    play_round(BASE >> 1, 1, 0, 0, 1'b1, over);
    play_round(BASE >> 1, 2, 2, 3, 1'b0, over);
    restart();

    // end_User in the last timer cycle at level 2 beats the timeout
    start_game(2'd2);
    play_round(BASE >> 2, 1, 0, 3, 1'b1, over);

    // Asynchronous reset mid-PLAY_USER
    bus.end_FPGA = 1'b1;
    tick();
    bus.end_FPGA = 1'b0;
    tick();
    chk_state("pre_async", 3);
    #2 reset = 1'b1;
    #1;
    chk_state("async", 0);
    chk("async.round", 32'(bus.round), 0);
    chk("async.win", 32'(bus.win), 0);
    chk("async.lose", 32'(bus.lose), 0);
    chk("async.timer", 32'(dut.timer), 0);

    // enter held across reset release produces no edge
    bus.enter = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("held_init", 0);
    tick();
    chk_state("held_setup", 1);
    tick();
    tick();
    chk_state("held_still", 1);
    bus.enter = 1'b0;
    tick();
    chk_state("released", 1);
    bus.level = 2'd0;
    start_game(2'd0);
    r = 1;
    over = 1'b0;
    while (!over && r <= MAXR) begin
      play_round(BASE, r, 0, 1, 1'b1, over);
      r++;
    end
    restart();

    // Randomized games
    for (int g = 0; g < 10; g++) begin
      lvl = $urandom_range(0, 3);
      lim = BASE >> lvl;
      start_game(2'(lvl));
      r = 1;
      over = 1'b0;
      while (!over && r <= MAXR) begin
        play_round(lim, r, $urandom_range(0, 3), $urandom_range(0, lim + 1),
                   ($urandom_range(0, 5) != 0), over);
        r++;
      end
      chk("rand.over", 32'(over), 1);
      restart();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
